// File: rtl/pulse_emitter_pkg.sv
// Shared types and default parameters for the pulse emitter and its bench.
package pulse_emitter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pe_state_t;

  localparam int unsigned PE_HIGH_CYCLES = 4;
  localparam int unsigned PE_LOW_CYCLES  = 4;
  localparam int unsigned PE_QUEUE_DEPTH = 3;

  // Phase counter only ever holds cycles-1, so clog2 of the larger phase suffices.
  function automatic int unsigned phaseWidth(int unsigned highCycles, int unsigned lowCycles);
    int unsigned m;
    int unsigned w;
    m = (highCycles > lowCycles) ? highCycles : lowCycles;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter; a simultaneous inc and dec leaves the count unchanged.
module sat_updown_counter #(
  parameter int unsigned MAX   = 3,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             full
);

  assign full = (count == WIDTH'(MAX));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/pulse_emitter.sv
// Stretches single-cycle triggers into pulses of fixed high width and minimum low gap,
// queueing triggers that arrive mid-pulse in a saturating counter.
module pulse_emitter
  import pulse_emitter_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = PE_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = PE_LOW_CYCLES,
  parameter int unsigned QUEUE_DEPTH = PE_QUEUE_DEPTH
) (
  input  logic                                 clock,
  input  logic                                 rst,
  input  logic                                 trigger,
  input  logic                                 clr_ovf,
  output logic                                 pulse_out,
  output logic                                 busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     pending,
  output logic                                 overflow
);

  localparam int unsigned PW = phaseWidth(HIGH_CYCLES, LOW_CYCLES);
  localparam int unsigned QW = $clog2(QUEUE_DEPTH + 1);

  pe_state_t   state;
  pe_state_t   stateNext;
  logic [PW-1:0] phase;
  logic [PW-1:0] phaseNext;
  logic        inc;
  logic        dec;
  logic        queueFull;
  logic        queueNonEmpty;
  logic        drop;

  assign queueNonEmpty = (pending != '0);
  assign busy          = (state != IDLE);
  assign drop          = inc & queueFull & ~dec;

  sat_updown_counter #(
    .MAX   (QUEUE_DEPTH),
    .WIDTH (QW)
  ) u_pendingCount (
    .clock (clock),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .count (pending),
    .full  (queueFull)
  );

  always_comb begin
    stateNext = state;
    phaseNext = phase;
    dec       = 1'b0;
    // An IDLE trigger with nothing queued is consumed directly; all others go through the queue.
    inc       = trigger & ~((state == IDLE) & ~queueNonEmpty);
    case (state)
      IDLE: begin
        if (trigger || queueNonEmpty) begin
          stateNext = HIGH;
          phaseNext = PW'(HIGH_CYCLES - 1);
          dec       = queueNonEmpty;
        end
      end
      HIGH: begin
        if (phase != '0) begin
          phaseNext = phase - PW'(1);
        end else begin
          stateNext = LOW;
          phaseNext = PW'(LOW_CYCLES - 1);
        end
      end
      LOW: begin
        if (phase != '0) begin
          phaseNext = phase - PW'(1);
        end else if (queueNonEmpty) begin
          stateNext = HIGH;
          phaseNext = PW'(HIGH_CYCLES - 1);
          dec       = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        phaseNext = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase     <= '0;
      pulse_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= stateNext;
      phase     <= phaseNext;
      pulse_out <= (stateNext == HIGH);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_emitter.sv
// Scoreboard bench: stimulus pushes expected pulse rise cycles, a monitor pops and compares.
module tb_pulse_emitter;
  import pulse_emitter_pkg::*;

  localparam int unsigned H  = PE_HIGH_CYCLES;
  localparam int unsigned L  = PE_LOW_CYCLES;
  localparam int unsigned D  = PE_QUEUE_DEPTH;
  localparam int unsigned QW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          rst, trigger, clr_ovf, pulse_out, busy, overflow;
  logic [QW-1:0] pending;
  logic          rst2, trig2, clr2, pulse2, busy2, ovf2;
  logic [0:0]    pend2;

  int cyc = 0;
  int passCount = 0;
  int checkCount = 0;
  int expRise[$];
  int riseCyc = 0;
  logic prevPulse = 1'b0;
  int c;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pulse_emitter dut (
    .clock     (clock),
    .rst       (rst),
    .trigger   (trigger),
    .clr_ovf   (clr_ovf),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  pulse_emitter #(
    .HIGH_CYCLES (1),
    .LOW_CYCLES  (1),
    .QUEUE_DEPTH (1)
  ) dut2 (
    .clock     (clock),
    .rst       (rst2),
    .trigger   (trig2),
    .clr_ovf   (clr2),
    .pulse_out (pulse2),
    .busy      (busy2),
    .pending   (pend2),
    .overflow  (ovf2)
  );

  task automatic check(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic trig();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Monitor: every rising edge of pulse_out consumes one expected rise cycle.
  always @(negedge clock) begin
    if (!rst) begin
      prevPulse = 1'b0;
    end else begin
      if (pulse_out && !prevPulse) begin
        if (expRise.size() == 0) check("unexpected_pulse", cyc, -1);
        else check("rise_cycle", cyc, expRise.pop_front());
        riseCyc = cyc;
      end else if (!pulse_out && prevPulse) begin
        check("high_width", cyc - riseCyc, H);
      end
      prevPulse = pulse_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; trigger = 1'b0; clr_ovf = 1'b0;
    rst2 = 1'b0; trig2 = 1'b0; clr2 = 1'b0;
    repeat (3) tick();
    check("rst_pulse", pulse_out, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Single trigger: high c+1..c+4, low c+5..c+8, idle at c+9.
    c = cyc;
    expRise.push_back(c + 1);
    trig();
    check("s1_busy_rise", busy, 1);
    check("s1_pending", pending, 0);
    repeat (7) tick();
    check("s1_busy_last_low", busy, 1);
    check("s1_pulse_last_low", pulse_out, 0);
    tick();
    check("s1_busy_fall", busy, 0);
    repeat (2) tick();

    // Triggers at c, c+2, c+3: pulses at c+1, c+9, c+17.
    c = cyc;
    expRise.push_back(c + 1);
    expRise.push_back(c + 9);
    expRise.push_back(c + 17);
    trig();
    tick();
    trig();
    check("s2_pending_1", pending, 1);
    trig();
    check("s2_pending_2", pending, 2);
    repeat (c + 17 - cyc) tick();
    check("s2_pending_0", pending, 0);
    check("s2_third_pulse", pulse_out, 1);
    waitIdle(40);
    repeat (2) tick();

    // Five triggers in one pulse: fifth is dropped, four pulses total.
    c = cyc;
    expRise.push_back(c + 1);
    expRise.push_back(c + 9);
    expRise.push_back(c + 17);
    expRise.push_back(c + 25);
    repeat (5) trig();
    check("s3_pending_full", pending, 3);
    check("s3_overflow_set", overflow, 1);
    waitIdle(60);
    check("s3_overflow_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("s3_overflow_clr", overflow, 0);
    repeat (2) tick();

    // Full queue plus a trigger on the last LOW cycle: net pending unchanged, no overflow.
    c = cyc;
    expRise.push_back(c + 1);
    expRise.push_back(c + 9);
    expRise.push_back(c + 17);
    expRise.push_back(c + 25);
    expRise.push_back(c + 33);
    repeat (4) trig();
    check("s4_pending_full", pending, 3);
    repeat (4) tick();
    trig();
    check("s4_pending_kept", pending, 3);
    check("s4_no_overflow", overflow, 0);
    check("s4_pulse_next", pulse_out, 1);
    waitIdle(80);
    repeat (2) tick();

    // Trigger on last LOW with empty queue: one IDLE cycle, then pulse.
    c = cyc;
    expRise.push_back(c + 1);
    expRise.push_back(c + 10);
    trig();
    repeat (7) tick();
    trig();
    check("s4b_idle_busy", busy, 0);
    check("s4b_idle_pending", pending, 1);
    tick();
    check("s4b_pulse", pulse_out, 1);
    check("s4b_pending_0", pending, 0);
    waitIdle(40);
    repeat (2) tick();

    // Asynchronous reset mid-HIGH with two queued triggers.
    c = cyc;
    expRise.push_back(c + 1);
    repeat (3) trig();
    check("s5_pending_2", pending, 2);
    #2 rst = 1'b0;
    #1;
    check("s5_async_pulse", pulse_out, 0);
    check("s5_async_busy", busy, 0);
    check("s5_async_pending", pending, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("s5_stays_idle", busy, 0);
    check("scoreboard_drained", expRise.size(), 0);

    // H=L=D=1 with trigger held high: toggles every cycle, overflow once the queue fills.
    rst2 = 1'b1;
    tick();
    check("s6_rst_pulse", pulse2, 0);
    trig2 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("s6_toggle", pulse2, i % 2);
      if (i == 3) check("s6_ovf_clear", ovf2, 0);
      if (i == 4) begin
        check("s6_ovf_set", ovf2, 1);
        check("s6_pending", pend2, 1);
      end
    end
    check("s6_busy", busy2, 1);
    trig2 = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pulse_emitter.md
# pulse_emitter

Converts single-cycle trigger pulses from the synchronous core (e.g. ALU result-ready or edge-detect strobes) into clean output pulses of a guaranteed high width and guaranteed low gap. This makes every pulse reliably visible to a slower or asynchronous consumer, such as an LED, an external board, or a two-flop input synchronizer on another clock. It is the transmit-side counterpart of the design's input synchronizer/edge detector. Triggers that arrive while a pulse is in progress are queued in a small saturating counter and emitted back-to-back.

## Interface
- `HIGH_CYCLES`, 4, number of clock cycles the output is held high per pulse; must be ≥1.
- `LOW_CYCLES`, 4, minimum number of low cycles between consecutive pulses; must be ≥1.
- `QUEUE_DEPTH`, 3, maximum number of pending (not yet started) triggers; must be ≥1.
- `clock`  input  1  rising-edge clock for all state.
- `rst`  input  1  asynchronous, active-low reset.
- `trigger`  input  1  synchronous request for one pulse, sampled each rising edge.
- `clr_ovf`  input  1  synchronous clear of the sticky `overflow` flag.
- `pulse_out`  output  1  registered emitted pulse.
- `busy`  output  1  high whenever the state is not IDLE.
- `pending`  output  $clog2(QUEUE_DEPTH+1)  count of queued triggers.
- `overflow`  output  1  sticky flag: a trigger was dropped because the queue was full.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE, `pulse_out`=0, `busy`=0, `pending`=0, `overflow`=0, phase counter=0.
- The FSM has three states: IDLE, HIGH, LOW.
- IDLE:
  - `trigger`=1 → HIGH. Load the phase counter with HIGH_CYCLES−1.
  - The trigger is consumed directly and is not queued.
- HIGH:
  - `pulse_out`=1.
  - While counter≠0, decrement.
  - When counter=0 → LOW. Load the counter with LOW_CYCLES−1.
- LOW:
  - `pulse_out`=0.
  - While counter≠0, decrement.
  - When counter=0 and `pending`>0 → HIGH. Decrement `pending` and reload HIGH_CYCLES−1.
  - When counter=0 and `pending`=0 → IDLE.
- Queueing: `trigger`=1 while in HIGH or LOW increments `pending` if `pending`<QUEUE_DEPTH. Otherwise `pending` is unchanged and `overflow` is set.
- Simultaneous trigger and dequeue (last LOW cycle with `pending`>0):
  - Net `pending` is unchanged.
  - No overflow is raised, even when `pending`=QUEUE_DEPTH.
- Trigger on the last LOW cycle with `pending`=0: `pending` becomes 1 and the FSM goes to IDLE. The next cycle sees `pending`>0 in IDLE. IDLE with `pending`>0 behaves exactly like an IDLE trigger and decrements `pending`. The result is still back-to-back emission with no extra gap beyond one IDLE cycle.
- Trigger in IDLE while `pending`>0 (only in the case above): `pending` is decremented and incremented in the same cycle, so it is net unchanged.
- `overflow`:
  - Set on any dropped trigger.
  - Cleared only by `clr_ovf`=1 or reset.
  - If set and clear occur in the same cycle, set wins.
- Counter width: $clog2(max(HIGH_CYCLES, LOW_CYCLES)). Use a minimum of 1 bit. No wrap-around is permitted.

## Timing
- `pulse_out`, `pending` and `overflow` are registered. `busy` is decoded from the registered state only.
- Latency: a trigger sampled at edge t in IDLE gives `pulse_out`=1 for cycles t+1 … t+HIGH_CYCLES. It then gives `pulse_out`=0 for cycles t+HIGH_CYCLES+1 … t+HIGH_CYCLES+LOW_CYCLES.
- Queued pulses repeat with period HIGH_CYCLES+LOW_CYCLES. The next high cycle is t+HIGH_CYCLES+LOW_CYCLES+1.
- `busy` rises in the same cycle as `pulse_out`. It falls the cycle after the final LOW cycle.
- Reset asserted mid-pulse: `pulse_out` drops to 0 immediately, without waiting for a clock edge. All queued triggers are discarded.
- Reset deassertion is assumed synchronous to `clock` by the upstream reset logic. The first trigger is accepted on the first edge with `rst`=1.

## Structure
- Package `pulse_emitter_pkg` holds:
  - typedef enum logic [1:0] `pe_state_t` {IDLE, HIGH, LOW};
  - localparam defaults for HIGH_CYCLES, LOW_CYCLES and QUEUE_DEPTH, shared with the bench.
- One sub-module, `sat_updown_counter`:
  - parameters MAX and width;
  - inputs inc and dec;
  - outputs count and full.
  - It is used for `pending`. It also produces the drop condition (inc & full & ~dec) that feeds `overflow`.
- The phase counter and FSM live in the top module.

## Test plan
All scenarios use the defaults H=4, L=4, D=3.
- Reset then a single trigger at cycle 10 → `pulse_out`=1 for cycles 11–14 and 0 for 15–18. `busy`=1 for 11–18. `pending` stays 0.
- Triggers at cycles 10, 12 and 13 → `pending` reads 1 then 2. Pulses go high at 11, 19 and 27. `pending` returns to 0 at 27.
- Five triggers during one pulse (`pending` reaches 3) → the fifth sets `overflow`=1. Exactly 4 pulses are emitted in total. `clr_ovf` then clears the flag.
- `pending`=3, with a trigger on the last LOW cycle → `pending` stays 3, `overflow` stays 0, and `pulse_out` is high on the next cycle.
- `rst` pulled low at cycle 13 mid-HIGH with `pending`=2 → `pulse_out`, `busy` and `pending` are 0 asynchronously. No pulses follow after release.
- Parameter sweep H=1, L=1, D=1 with `trigger` held high continuously → `pulse_out` toggles every cycle after the first. `overflow` is set once the queue fills.
